// File: rtl/sync_stream_checker.sv
// Capture-domain checker for a synchronized free-running counter: qualifies each
// sample's modular step against the previous one, tracks lock and counts failures.
module sync_stream_checker #(
    parameter int WIDTH       = 4,
    parameter int MIN_STEP    = 0,
    parameter int MAX_STEP    = 2,
    parameter int ACQ_GOOD    = 3,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic [1:0]       state,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    output logic [7:0]       loss_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_prev,
    output logic [WIDTH-1:0] first_err_cur
);

    // Handshake: sample is consumed in any cycle where sample_valid is high; there
    // is no backpressure, the checker accepts one sample per clock unconditionally.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_LOST  = 2'd3
    } state_t;

    localparam int GW = (ACQ_GOOD > 0) ? $clog2(ACQ_GOOD + 1) : 1;
    localparam int BW = (LOSS_THRESH > 0) ? $clog2(LOSS_THRESH + 1) : 1;

    localparam logic [GW-1:0]    GR_ONE  = GW'(1);
    localparam logic [BW-1:0]    BR_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           st;
    logic [WIDTH-1:0] prev;
    logic [GW-1:0]    good_run;
    logic [BW-1:0]    bad_run;

    // Wraparound subtraction gives the modular increment directly.
    logic [WIDTH-1:0] delta;
    int               delta_i;
    logic             step_legal;

    assign delta      = sample - prev;
    assign delta_i    = int'(delta);
    assign step_legal = (delta_i >= MIN_STEP) && (delta_i <= MAX_STEP);
    assign state      = st;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            st              <= S_IDLE;
            locked          <= 1'b0;
            err_pulse       <= 1'b0;
            prev            <= '0;
            good_run        <= '0;
            bad_run         <= '0;
            sample_count    <= '0;
            error_count     <= '0;
            loss_count      <= '0;
            first_err_valid <= 1'b0;
            first_err_prev  <= '0;
            first_err_cur   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (sample_valid) begin
                prev <= sample;
                if (sample_count != '1) sample_count <= sample_count + CNT_ONE;
                case (st)
                    S_IDLE, S_LOST: begin
                        st       <= S_ACQ;
                        good_run <= '0;
                    end
                    S_ACQ: begin
                        if (!step_legal) begin
                            good_run <= '0;
                        end else if (int'(good_run) + 1 >= ACQ_GOOD) begin
                            st       <= S_TRACK;
                            locked   <= 1'b1;
                            good_run <= '0;
                            bad_run  <= '0;
                        end else begin
                            good_run <= good_run + GR_ONE;
                        end
                    end
                    S_TRACK: begin
                        if (step_legal) begin
                            bad_run <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (error_count != '1) error_count <= error_count + CNT_ONE;
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_prev  <= prev;
                                first_err_cur   <= sample;
                            end
                            // The error that crosses the threshold is still counted above.
                            if (int'(bad_run) + 1 >= LOSS_THRESH) begin
                                st      <= S_LOST;
                                locked  <= 1'b0;
                                bad_run <= '0;
                                if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
                            end else begin
                                bad_run <= bad_run + BR_ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_stream_checker.sv
// Bench for sync_stream_checker: directed scenarios from the test plan, a
// saturation run on a narrow-counter instance, and random stimulus vs a model.
module tb_sync_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n, clr, sample_valid;
    logic [3:0]  sample;
    logic [1:0]  state;
    logic        locked, err_pulse;
    logic [15:0] sample_count, error_count;
    logic [7:0]  loss_count;
    logic        first_err_valid;
    logic [3:0]  first_err_prev, first_err_cur;

    logic        s_clr, s_valid;
    logic [3:0]  s_sample;
    logic [1:0]  s_state;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_sample_count, s_error_count;
    logic [7:0]  s_loss_count;
    logic        s_fev;
    logic [3:0]  s_fep, s_fec;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers, follows the step/lock rules directly)
    int m_state, m_prev, m_good, m_bad, m_scnt, m_ecnt, m_lcnt, m_fep, m_fec;
    bit m_fev, m_pulse;

    sync_stream_checker dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sample_valid(sample_valid), .sample(sample),
        .state(state), .locked(locked), .err_pulse(err_pulse), .sample_count(sample_count),
        .error_count(error_count), .loss_count(loss_count), .first_err_valid(first_err_valid),
        .first_err_prev(first_err_prev), .first_err_cur(first_err_cur)
    );

    sync_stream_checker #(.CNT_W(4), .LOSS_THRESH(32)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .sample_valid(s_valid), .sample(s_sample),
        .state(s_state), .locked(s_locked), .err_pulse(s_err_pulse), .sample_count(s_sample_count),
        .error_count(s_error_count), .loss_count(s_loss_count), .first_err_valid(s_fev),
        .first_err_prev(s_fep), .first_err_cur(s_fec)
    );

    always #5 clk = ~clk;

    task automatic model_apply(input bit v, input bit c, input int s);
        int  d;
        bit  legal;
        m_pulse = 0;
        if (!rst_n || c) begin
            m_state = 0; m_prev = 0; m_good = 0; m_bad = 0;
            m_scnt = 0; m_ecnt = 0; m_lcnt = 0; m_fev = 0; m_fep = 0; m_fec = 0;
        end else if (v) begin
            d     = (s - m_prev + 16) % 16;
            legal = (d >= 0) && (d <= 2);
            if (m_scnt < 65535) m_scnt++;
            if (m_state == 0 || m_state == 3) begin
                m_state = 1; m_good = 0;
            end else if (m_state == 1) begin
                if (legal) begin
                    m_good++;
                    if (m_good == 3) begin m_state = 2; m_bad = 0; m_good = 0; end
                end else m_good = 0;
            end else if (legal) begin
                m_bad = 0;
            end else begin
                m_pulse = 1;
                if (m_ecnt < 65535) m_ecnt++;
                if (!m_fev) begin m_fev = 1; m_fep = m_prev; m_fec = s; end
                m_bad++;
                if (m_bad == 4) begin
                    m_state = 3; m_bad = 0;
                    if (m_lcnt < 255) m_lcnt++;
                end
            end
            m_prev = s;
        end
    endtask

    // Drive one cycle on the main instance; outputs are looked at 1 time unit after the edge.
    task automatic tick(input bit v, input bit c, input int s);
        sample_valid = v; clr = c; sample = 4'(s);
        @(posedge clk); #1;
        model_apply(v, c, s);
    endtask

    task automatic tick_sat(input bit v, input bit c, input int s);
        s_valid = v; s_clr = c; s_sample = 4'(s);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(1, 0, 5);
        tick(1, 0, 6);
        rst_n = 1'b1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (locked !== 1'b0 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got locked=%b pulse=%b expected 0/0", locked, err_pulse); end
        n_checks++; if (sample_count !== 16'd0 || error_count !== 16'd0 || loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", sample_count, error_count, loss_count); end
        n_checks++; if (first_err_valid !== 1'b0 || first_err_prev !== 4'd0 || first_err_cur !== 4'd0) begin n_fail++; $display("FAIL reset_first_err: got v=%b p=%0d c=%0d expected 0/0/0", first_err_valid, first_err_prev, first_err_cur); end
        n_checks++; if (s_state !== 2'd0 || s_sample_count !== 4'd0) begin n_fail++; $display("FAIL reset_sat: got state=%0d cnt=%0d expected 0/0", s_state, s_sample_count); end
    endtask

    task automatic test_acquire;
        int exp_st[5] = '{1, 1, 1, 2, 2};
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, i);
            n_checks++; if (state !== 2'(exp_st[i])) begin n_fail++; $display("FAIL acq_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            n_checks++; if (locked !== (exp_st[i] == 2)) begin n_fail++; $display("FAIL acq_locked[%0d]: got %b expected %b", i, locked, exp_st[i] == 2); end
        end
        n_checks++; if (sample_count !== 16'd5 || error_count !== 16'd0) begin n_fail++; $display("FAIL acq_counts: got %0d/%0d expected 5/0", sample_count, error_count); end
    endtask

    task automatic test_wraparound;
        int seq[8] = '{6, 8, 10, 12, 14, 15, 0, 2};
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, seq[i]);
            n_checks++; if (err_pulse !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL wrap_step[%0d]: got pulse=%b locked=%b expected 0/1", i, err_pulse, locked); end
        end
        n_checks++; if (error_count !== 16'd0) begin n_fail++; $display("FAIL wrap_errors: got %0d expected 0", error_count); end
    endtask

    task automatic test_glitch;
        tick(1, 0, 3); tick(1, 0, 4); tick(1, 0, 5);
        tick(1, 0, 9);
        n_checks++; if (err_pulse !== 1'b1 || error_count !== 16'd1 || state !== 2'd2) begin n_fail++; $display("FAIL glitch_err: got pulse=%b cnt=%0d state=%0d expected 1/1/2", err_pulse, error_count, state); end
        n_checks++; if (first_err_valid !== 1'b1 || first_err_prev !== 4'd5 || first_err_cur !== 4'd9) begin n_fail++; $display("FAIL glitch_capture: got v=%b p=%0d c=%0d expected 1/5/9", first_err_valid, first_err_prev, first_err_cur); end
        tick(1, 0, 10);
        n_checks++; if (err_pulse !== 1'b0 || error_count !== 16'd1) begin n_fail++; $display("FAIL glitch_recover: got pulse=%b cnt=%0d expected 0/1", err_pulse, error_count); end
        tick(1, 0, 15);
        n_checks++; if (error_count !== 16'd2 || first_err_prev !== 4'd5 || first_err_cur !== 4'd9) begin n_fail++; $display("FAIL glitch_sticky: got cnt=%0d p=%0d c=%0d expected 2/5/9", error_count, first_err_prev, first_err_cur); end
        tick(1, 0, 0);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL glitch_state: got %0d expected 2", state); end
    endtask

    task automatic test_clr_with_valid;
        tick(1, 1, 7);
        n_checks++; if (state !== 2'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL clr_state: got %0d locked=%b expected 0/0", state, locked); end
        n_checks++; if (sample_count !== 16'd0 || error_count !== 16'd0 || loss_count !== 8'd0 || first_err_valid !== 1'b0) begin n_fail++; $display("FAIL clr_counts: got %0d/%0d/%0d fev=%b expected 0/0/0/0", sample_count, error_count, loss_count, first_err_valid); end
        tick(0, 0, 3); tick(0, 0, 9);
        n_checks++; if (state !== 2'd0 || sample_count !== 16'd0) begin n_fail++; $display("FAIL idle_hold: got state=%0d cnt=%0d expected 0/0", state, sample_count); end
    endtask

    task automatic test_loss;
        int bad[4] = '{8, 0, 8, 0};
        int good[4] = '{1, 2, 3, 4};
        int exp_re[4] = '{1, 1, 1, 2};
        tick(1, 0, 13); tick(1, 0, 14); tick(1, 0, 15); tick(1, 0, 0);
        n_checks++; if (state !== 2'd2 || sample_count !== 16'd4) begin n_fail++; $display("FAIL loss_lock: got state=%0d cnt=%0d expected 2/4", state, sample_count); end
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, bad[i]);
            n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL loss_pulse[%0d]: got %b expected 1", i, err_pulse); end
            n_checks++; if (state !== ((i == 3) ? 2'd3 : 2'd2)) begin n_fail++; $display("FAIL loss_state[%0d]: got %0d expected %0d", i, state, (i == 3) ? 3 : 2); end
        end
        n_checks++; if (error_count !== 16'd4 || loss_count !== 8'd1 || locked !== 1'b0) begin n_fail++; $display("FAIL loss_counts: got err=%0d loss=%0d locked=%b expected 4/1/0", error_count, loss_count, locked); end
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, good[i]);
            n_checks++; if (state !== 2'(exp_re[i]) || err_pulse !== 1'b0) begin n_fail++; $display("FAIL reacq_state[%0d]: got %0d pulse=%b expected %0d/0", i, state, err_pulse, exp_re[i]); end
        end
        n_checks++; if (error_count !== 16'd4) begin n_fail++; $display("FAIL reacq_errors: got %0d expected 4", error_count); end
    endtask

    task automatic test_saturation;
        int pulses = 0;
        tick_sat(1, 0, 0); tick_sat(1, 0, 1); tick_sat(1, 0, 2); tick_sat(1, 0, 3);
        n_checks++; if (s_state !== 2'd2) begin n_fail++; $display("FAIL sat_lock: got %0d expected 2", s_state); end
        for (int i = 0; i < 20; i++) begin
            tick_sat(1, 0, (i % 2 == 0) ? 8 : 0);
            if (s_err_pulse === 1'b1) pulses++;
        end
        tick_sat(0, 0, 0);
        n_checks++; if (pulses != 20) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 20", pulses); end
        n_checks++; if (s_error_count !== 4'd15 || s_sample_count !== 4'd15) begin n_fail++; $display("FAIL sat_counts: got err=%0d samp=%0d expected 15/15", s_error_count, s_sample_count); end
        n_checks++; if (s_state !== 2'd2 || s_loss_count !== 8'd0) begin n_fail++; $display("FAIL sat_state: got %0d loss=%0d expected 2/0", s_state, s_loss_count); end
    endtask

    task automatic test_random;
        int s, step;
        tick(0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            step = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 15);
            s = (m_prev + step) % 16;
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2, s);
            n_checks++;
            if (state !== 2'(m_state) || locked !== (m_state == 2) || err_pulse !== m_pulse ||
                sample_count !== 16'(m_scnt) || error_count !== 16'(m_ecnt) || loss_count !== 8'(m_lcnt) ||
                first_err_valid !== m_fev || first_err_prev !== 4'(m_fep) || first_err_cur !== 4'(m_fec)) begin
                n_fail++;
                $display("FAIL random[%0d]: got st=%0d lk=%b p=%b sc=%0d ec=%0d lc=%0d fe=%b/%0d/%0d expected st=%0d p=%b sc=%0d ec=%0d lc=%0d fe=%b/%0d/%0d",
                         i, state, locked, err_pulse, sample_count, error_count, loss_count, first_err_valid, first_err_prev, first_err_cur,
                         m_state, m_pulse, m_scnt, m_ecnt, m_lcnt, m_fev, m_fep, m_fec);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; sample_valid = 1'b0; sample = '0;
        s_clr = 1'b0; s_valid = 1'b0; s_sample = '0;
        test_reset;
        test_acquire;
        test_wraparound;
        test_glitch;
        test_clr_with_valid;
        test_loss;
        test_saturation;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_stream_checker.md
Name: sync_stream_checker

Overview:
- Receive-side checker for a free-running binary counter (default 4 bits) that is launched in one clock domain and captured through a synchronizer in another.
- Runs in the capture clock domain and qualifies every captured sample against the previous one.
- Counts samples and illegal steps (synchronizer failures or metastability corruption) and tracks lock.
- Its outputs drive the status pins so synchronizer failure rates can be measured on silicon.

Parameters:
- WIDTH, 4: width of the captured counter sample.
- MIN_STEP, 0: smallest legal modular increment between consecutive samples.
- MAX_STEP, 2: largest legal modular increment between consecutive samples.
- ACQ_GOOD, 3: consecutive legal steps required to reach lock.
- LOSS_THRESH, 4: consecutive illegal steps while locked that declare loss of lock.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  capture-domain clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous clear of statistics and state machine.
- sample_valid  in  1  sample holds a newly captured value this cycle.
- sample  in  WIDTH  synchronized counter value.
- state  out  2  0=IDLE, 1=ACQ, 2=TRACK, 3=LOST.
- locked  out  1  high exactly while state==TRACK.
- err_pulse  out  1  one-cycle pulse for each illegal step counted.
- sample_count  out  CNT_W  valid samples since reset/clr, saturating.
- error_count  out  CNT_W  illegal steps counted in TRACK, saturating.
- loss_count  out  8  TRACK->LOST transitions, saturating at 255.
- first_err_valid  out  1  first_err_* hold a captured error.
- first_err_prev  out  WIDTH  previous sample at first counted error.
- first_err_cur  out  WIDTH  offending sample at first counted error.

Behaviour:
- One clock; reset is synchronous and active-low. rst_n has priority over clr.
- Reset and clr produce identical results:
  - state=IDLE, locked=0, err_pulse=0.
  - All counters=0, first_err_*=0, first_err_valid=0.
  - Internal prev=0, good_run=0, bad_run=0.
- clr in the same cycle as sample_valid: clr wins, the sample is dropped and not counted.
- All outputs are registered. The effect of a sample appears on the cycle after sample_valid is high.
- With sample_valid low, nothing changes, and err_pulse is 0.
- Step rule:
  - delta = (sample - prev) mod 2^WIDTH, using WIDTH-bit wraparound subtraction; 15->1 is delta 2 for WIDTH=4.
  - A step is legal iff MIN_STEP <= delta <= MAX_STEP.
  - prev <= sample on every valid sample, legal or not.
- sample_count increments on every valid sample in every state; it saturates at all-ones.
- IDLE: on valid, load prev, go to ACQ with good_run=0. No step is checked.
- ACQ:
  - Legal step: good_run+1. When it reaches ACQ_GOOD, go to TRACK and clear bad_run.
  - Illegal step: good_run=0, stay in ACQ. Not counted as an error, no err_pulse.
- TRACK:
  - Legal step: bad_run=0.
  - Illegal step: err_pulse=1, error_count+1 (saturating), bad_run+1.
  - If first_err_valid=0, capture prev and sample into first_err_prev/first_err_cur and set first_err_valid. The capture is sticky until reset/clr.
  - When bad_run reaches LOSS_THRESH, go to LOST and increment loss_count (saturating). The error that triggers loss is itself counted.
- LOST: on the next valid sample, load prev, go to ACQ with good_run=0. No step is checked and no error is counted.
- Counters hold at maximum with no wrap; err_pulse still pulses when error_count is saturated.

Test Plan:
- Reset, then valid samples 0,1,2,3,4 every cycle:
  - State goes IDLE->ACQ->ACQ->ACQ->TRACK.
  - locked rises one cycle after the sample 3.
  - sample_count=5, error_count=0.
- Wraparound: locked, samples 14,15,0,2 -> all legal, no err_pulse, error_count stays 0.
- Single glitch: locked at prev=5, samples 9,10 ->
  - err_pulse once; error_count=1; state stays TRACK.
  - first_err_prev=5, first_err_cur=9, first_err_valid=1.
  - A second error later leaves first_err_* unchanged.
- Loss: locked at prev=0, samples 8,0,8,0 (four illegal steps) ->
  - error_count=4, loss_count=1, state=LOST.
  - Next samples 1,2,3,4 -> ACQ, then TRACK again.
- clr asserted together with sample_valid mid-TRACK ->
  - Next cycle state=IDLE, all counts 0, first_err_valid=0.
  - The sample is dropped, so sample_count=0.
- Saturation with CNT_W=4: force 20 illegal steps with LOSS_THRESH=32 -> error_count holds 15 and err_pulse fires 20 times; sample_count holds 15.
